// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned DEPTH_DEFAULT = 1024;
    localparam int unsigned LEN_W         = 16;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_LAST,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream loader: receives a 16-bit word count then little-endian words,
// and writes them into instruction memory while holding the CPU in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    state_e              r_state;
    state_e              w_state_d;
    logic [LEN_W-1:0]    r_len;
    logic [1:0]          r_byte_cnt;
    logic [LEN_W-1:0]    r_word_idx;
    logic [23:0]         r_asm;
    logic                r_rx_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_cpu_hold;

    logic                w_acc;
    logic                w_begin;
    logic                w_last_word;
    logic [LEN_W-1:0]    w_len_full;

    assign w_acc       = rx_valid && r_rx_ready;
    assign w_begin     = start && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);
    assign w_last_word = (r_word_idx == r_len - LEN_W'(1));
    assign w_len_full  = {rx_data, r_len[7:0]};

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) w_state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (w_acc) w_state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (w_acc) begin
                    if (w_len_full == '0)
                        w_state_d = ST_DONE;
                    else if (32'(w_len_full) > 32'(DEPTH))
                        w_state_d = ST_ERR;
                    else
                        w_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_acc && r_byte_cnt == 2'd3 && w_last_word) w_state_d = ST_LAST;
            end
            ST_LAST:  w_state_d = ST_DONE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    // State register and state-decoded outputs, registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cpu_hold <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_rx_ready <= (w_state_d == ST_LEN_LO) || (w_state_d == ST_LEN_HI) ||
                          (w_state_d == ST_DATA);
            r_busy     <= (w_state_d == ST_LEN_LO) || (w_state_d == ST_LEN_HI) ||
                          (w_state_d == ST_DATA)   || (w_state_d == ST_LAST);
            r_done     <= (w_state_d == ST_DONE);
            r_err      <= (w_state_d == ST_ERR);
            r_cpu_hold <= (w_state_d != ST_DONE);
        end
    end

    // Length capture, byte assembly and write-port generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_word_idx <= '0;
            r_asm      <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_begin) begin
                r_len      <= '0;
                r_byte_cnt <= '0;
                r_word_idx <= '0;
            end else if (w_acc) begin
                case (r_state)
                    ST_LEN_LO: r_len[7:0]  <= rx_data;
                    ST_LEN_HI: r_len[15:8] <= rx_data;
                    ST_DATA: begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_asm[7:0]   <= rx_data;
                            2'd1: r_asm[15:8]  <= rx_data;
                            2'd2: r_asm[23:16] <= rx_data;
                            default: begin
                                r_we    <= 1'b1;
                                r_wdata <= {rx_data, r_asm};
                                r_waddr <= {14'd0, r_word_idx, 2'b00};
                                // Index stays on the final word so it never passes DEPTH-1
                                if (!w_last_word) r_word_idx <= r_word_idx + LEN_W'(1);
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx_ready = r_rx_ready;
    assign we       = r_we;
    assign waddr    = r_waddr;
    assign wdata    = r_wdata;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign cpu_hold = r_cpu_hold;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected memory writes.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [7:0]  rx_data  = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    imem_loader #(.DEPTH(1024)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_we     = 0;
    int          we_base;
    logic [31:0] img [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Every write strobe is matched against the next expected write
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && we === 1'b1) begin
            n_we++;
            if (exp_q.size() == 0) begin
                check("we_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("waddr", waddr, e.addr);
                check("wdata", wdata, e.data);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("rx_ready_timeout", 32'd0, 32'd1);
        else         @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_len(input logic [15:0] n);
        send_byte(n[7:0], 0);
        send_byte(n[15:8], 0);
    endtask

    task automatic send_word(input logic [31:0] w, input int gmax);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], int'($urandom_range(0, gmax)));
    endtask

    task automatic wait_end();
        int t = 0;
        while (done !== 1'b1 && err !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("session_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_exp(input int k, input logic [31:0] d);
        wr_t e;
        e.addr = 32'(4 * k);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic load_img(input int n, input int gmax);
        for (int k = 0; k < n; k++) push_exp(k, img[k]);
        pulse_start();
        send_len(16'(n));
        for (int k = 0; k < n; k++) send_word(img[k], gmax);
        wait_end();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_we",       32'(we),       32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_waddr",    waddr,         32'd0);
        check("rst_wdata",    wdata,         32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Two-word load with exact strobe/done timing
        push_exp(0, 32'h2401_0013);
        push_exp(1, 32'h0800_0000);
        pulse_start();
        check("t1_busy",     32'(busy),     32'd1);
        check("t1_rx_ready", 32'(rx_ready), 32'd1);
        send_len(16'h0002);
        send_word(32'h2401_0013, 0);
        send_word(32'h0800_0000, 0);
        check("t1_last_we",       32'(we),       32'd1);
        check("t1_last_rx_ready", 32'(rx_ready), 32'd0);
        check("t1_last_busy",     32'(busy),     32'd1);
        check("t1_last_done",     32'(done),     32'd0);
        @(negedge clk);
        check("t1_done",     32'(done),     32'd1);
        check("t1_we_off",   32'(we),       32'd0);
        check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t1_busy_off", 32'(busy),     32'd0);
        check("t1_n_we",     32'(n_we),     32'd2);

        // Zero length from DONE: new session, then straight to DONE
        we_base = n_we;
        pulse_start();
        check("t3_done_clr", 32'(done),     32'd0);
        check("t3_hold",     32'(cpu_hold), 32'd1);
        send_len(16'h0000);
        wait_end();
        check("t3_done",     32'(done),     32'd1);
        check("t3_err",      32'(err),      32'd0);
        check("t3_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t3_no_we",    32'(n_we - we_base), 32'd0);

        // Length 1025 exceeds capacity
        pulse_start();
        send_len(16'h0401);
        wait_end();
        repeat (5) @(negedge clk);
        check("t2_err",      32'(err),      32'd1);
        check("t2_done",     32'(done),     32'd0);
        check("t2_cpu_hold", 32'(cpu_hold), 32'd1);
        check("t2_rx_ready", 32'(rx_ready), 32'd0);
        check("t2_busy",     32'(busy),     32'd0);
        check("t2_no_we",    32'(n_we - we_base), 32'd0);

        // 16 words without gaps, then the same image with random gaps
        for (int k = 0; k < 16; k++) img[k] = $urandom;
        load_img(16, 0);
        check("t4_done", 32'(done), 32'd1);
        check("t4_err",  32'(err),  32'd0);
        load_img(16, 5);
        check("t4g_done",  32'(done),        32'd1);
        check("t4g_empty", 32'(exp_q.size()), 32'd0);
        check("t4_n_we",   32'(n_we - we_base), 32'd32);

        // start during DATA is ignored
        we_base = n_we;
        for (int k = 0; k < 3; k++) push_exp(k, img[k]);
        pulse_start();
        send_len(16'h0003);
        send_word(img[0], 0);
        pulse_start();
        check("t5_busy",     32'(busy),     32'd1);
        check("t5_rx_ready", 32'(rx_ready), 32'd1);
        send_word(img[1], 0);
        send_word(img[2], 0);
        wait_end();
        check("t5_done", 32'(done), 32'd1);
        check("t5_n_we", 32'(n_we - we_base), 32'd3);

        // Reset after 6 data bytes of a 3-word load
        we_base = n_we;
        push_exp(0, img[5]);
        pulse_start();
        send_len(16'h0003);
        send_word(img[5], 0);
        send_byte(img[6][7:0], 0);
        send_byte(img[6][15:8], 0);
        rst_n = 1'b0;
        #1;
        check("t6_busy",     32'(busy),     32'd0);
        check("t6_cpu_hold", 32'(cpu_hold), 32'd1);
        check("t6_rx_ready", 32'(rx_ready), 32'd0);
        check("t6_we",       32'(we),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_n_we",      32'(n_we - we_base), 32'd1);
        check("t6_empty",     32'(exp_q.size()), 32'd0);
        load_img(3, 2);
        check("t6_reload_done", 32'(done),     32'd1);
        check("t6_reload_hold", 32'(cpu_hold), 32'd0);

        repeat (3) @(negedge clk);
        check("final_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 1024, instruction-memory capacity in 32-bit words; the maximum accepted word count.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a load session.
REQ-005 rx_data  input  8  incoming byte.
REQ-006 rx_valid  input  1  rx_data is valid this cycle.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle; a byte transfers when rx_valid and rx_ready are both 1 at a rising edge.
REQ-008 we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 waddr  output  32  byte address of the word being written, word-aligned (bits [1:0] = 0), so that waddr[11:2] indexes the memory as pc[11:2] does.
REQ-010 wdata  output  32  word being written.
REQ-011 busy  output  1  session in progress.
REQ-012 done  output  1  last session completed without error.
REQ-013 err  output  1  last session aborted because the length exceeded DEPTH.
REQ-014 cpu_hold  output  1  holds the CPU in reset while 1.

Function
REQ-015 States: IDLE, LEN_LO, LEN_HI, DATA, LAST, DONE, ERR.
REQ-016 IDLE->LEN_LO on start; start in DONE or ERR also -> LEN_LO and clears done/err; start in any other state is ignored.
REQ-017 rx_ready = 1 only in LEN_LO, LEN_HI and DATA; 0 in all other states.
REQ-018 LEN_LO: accepted byte -> N[7:0], then LEN_HI.
REQ-019 LEN_HI: accepted byte -> N[15:8], then next state is:
  - DONE if N = 0;
  - ERR if N > DEPTH;
  - DATA otherwise.
REQ-020 DATA: bytes are assembled little-endian; the first byte of each group of 4 -> wdata[7:0], the fourth -> wdata[31:24].
REQ-021 On acceptance of the 4th byte of word k (k from 0):
  - we = 1 in the following cycle only;
  - in that cycle wdata = assembled word and waddr = 4*k.
REQ-022 The next word's bytes may be accepted during the we cycle; wdata/waddr shall stay stable throughout the we cycle.
REQ-023 When word N-1 is accepted, the next state is LAST (rx_ready = 0) with we = 1; LAST -> DONE after one cycle, so done rises one cycle after the final we.
REQ-024 Byte counter is 2 bits and wraps 3->0 per word; word index is 16 bits and never exceeds DEPTH-1.
REQ-025 busy = 1 in LEN_LO, LEN_HI, DATA and LAST.
REQ-026 done = 1 only in DONE; err = 1 only in ERR.
REQ-027 cpu_hold = 0 only in DONE; it is 1 in all other states, including during a reload.
REQ-028 ERR performs no writes; it leaves ERR only on start.
REQ-029 When rx_valid = 0, no state advances; any number of idle cycles between bytes is legal.

Reset
REQ-030 rst_n low asynchronously forces:
  - state IDLE; we, busy, done, err = 0;
  - cpu_hold = 1;
  - rx_ready = 0;
  - waddr, wdata, N, counters = 0.
REQ-031 Reset mid-session discards the partial word with no write; after reset the loader waits for a new start.

Structure
REQ-032 State encoding and DEPTH default reside in a shared package, e.g. cpu_pkg.
REQ-033 The state machine, counters and byte assembler are flat in imem_loader; no sub-module.
REQ-034 The memory itself is outside this block; the write port is driven by we/waddr/wdata.

Verification
REQ-035 Length 0x0002, then bytes 13 00 01 24 / 00 00 00 08 -> we twice: waddr 0x0 wdata 0x24010013, then waddr 0x4 wdata 0x08000000; done 1 one cycle after the second we; cpu_hold 0.
REQ-036 Length 0x0401 (1025) with DEPTH = 1024 -> ERR, err = 1, we never asserted, cpu_hold stays 1.
REQ-037 Length 0x0000 -> DONE directly, no we, done = 1.
REQ-038 Random rx_valid gaps (0-5 cycles) over 16 words -> writes identical to the gap-free run.
REQ-039 rst_n low after byte 6 of a 3-word load -> only word 0 written, state IDLE, cpu_hold = 1; a following start with a full load succeeds.
REQ-040 start while in DATA -> ignored, load completes normally; start in DONE -> new session, cpu_hold returns to 1.
